// File: rtl/button_conditioner.sv
// ============================================================================
//  Module   : button_conditioner
//  Purpose  : Synchronises and debounces a raw push-button. Emits a one-cycle
//             press pulse per debounced press, a debounced level, and a
//             wrapping 8-bit press counter.
//  Options  : BUTTON_CONDITIONER_REPEAT_EN adds auto-repeat pulses while the
//             button stays held (REPEAT_DELAY first, then every REPEAT_PERIOD).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_raw,
  output logic       button,
  output logic       button_level,
  output logic [7:0] press_count
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             press_evt;
  logic             repeat_evt;
  logic             pulse_nxt;
  logic             level_nxt;

  // Two-flop synchroniser; only s is seen by the debounce FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= button_raw;
      s  <= s1;
    end
  end

  // FSM state and debounce counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= CNT_ZERO;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: a level change is accepted only after
  // DEBOUNCE_CYCLES consecutive agreeing samples.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press_evt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s) begin
          state_nxt = ST_ARM;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_ARM: begin
        if (!s) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HELD;
          cnt_nxt   = CNT_ZERO;
          press_evt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!s) begin
          state_nxt = ST_RELEASE;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_RELEASE: begin
        if (s) begin
          state_nxt = ST_HELD;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = CNT_ZERO;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_DELAY_C  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] REP_PERIOD_C = CNT_W'(REPEAT_PERIOD);

  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] rep_cnt_nxt;
  logic             rep_first;
  logic             rep_first_nxt;
  logic [CNT_W-1:0] rep_target;

  // Repeat counter: counts held cycles, freezes while a release is being
  // debounced (so a bounce back to HELD resumes), clears once fully released.
  always_comb begin
    rep_cnt_nxt   = rep_cnt;
    rep_first_nxt = rep_first;
    repeat_evt    = 1'b0;
    rep_target    = rep_first ? REP_DELAY_C : REP_PERIOD_C;
    if ((state == ST_HELD) && s) begin
      if ((rep_cnt + CNT_ONE) == rep_target) begin
        repeat_evt    = 1'b1;
        rep_cnt_nxt   = CNT_ZERO;
        rep_first_nxt = 1'b0;
      end else begin
        rep_cnt_nxt = rep_cnt + CNT_ONE;
      end
    end else if (state_nxt == ST_IDLE) begin
      rep_cnt_nxt   = CNT_ZERO;
      rep_first_nxt = 1'b1;
    end
  end

  // Repeat counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt   <= CNT_ZERO;
      rep_first <= 1'b1;
    end else begin
      rep_cnt   <= rep_cnt_nxt;
      rep_first <= rep_first_nxt;
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY != REPEAT_PERIOD);
  assign repeat_evt        = 1'b0;
`endif

  // Output decode: level follows the debounced state, pulse on accepted press.
  always_comb begin
    pulse_nxt = press_evt | repeat_evt;
    level_nxt = (state_nxt == ST_HELD) || (state_nxt == ST_RELEASE);
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      button       <= 1'b0;
      button_level <= 1'b0;
      press_count  <= 8'd0;
    end else begin
      button       <= pulse_nxt;
      button_level <= level_nxt;
      press_count  <= press_count + {7'd0, pulse_nxt};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
//  Module   : tb_button_conditioner
//  Purpose  : Self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic       clk;
  logic       rst;
  logic       button_raw;
  logic       button;
  logic       button_level;
  logic [7:0] press_count;

  int n_checks = 0;
  int n_errors = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(16),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button_raw(button_raw),
    .button(button),
    .button_level(button_level),
    .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The FSM sees the raw input two edges late. The debounced level flips
  // when the last D seen samples all disagree with it; a rising flip pulses.
  bit         raw_q[$];
  bit         seen_q[$];
  bit         prev_seen;
  bit         m_level;
  bit         m_pulse;
  logic [7:0] m_cnt;
  int         rep_t;

  task automatic model_reset();
    raw_q     = '{1'b0, 1'b0};
    seen_q    = {};
    prev_seen = 1'b0;
    m_level   = 1'b0;
    m_pulse   = 1'b0;
    m_cnt     = 8'd0;
    rep_t     = 0;
  endtask

  task automatic model_step(input bit raw);
    bit cur;
    bit all_opp;
    cur = raw_q[0];
    void'(raw_q.pop_front());
    raw_q.push_back(raw);
    seen_q.push_back(cur);
    if (seen_q.size() > D) void'(seen_q.pop_front());
    m_pulse = 1'b0;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
    if (m_level && prev_seen && cur) begin
      rep_t++;
      if (rep_t == RD || (rep_t > RD && ((rep_t - RD) % RP) == 0)) m_pulse = 1'b1;
    end
`endif
    all_opp = (seen_q.size() == D);
    foreach (seen_q[i]) if (seen_q[i] == m_level) all_opp = 1'b0;
    if (all_opp) begin
      m_level = !m_level;
      if (m_level) m_pulse = 1'b1;
      else rep_t = 0;
    end
    if (m_pulse) m_cnt = m_cnt + 8'd1;
    prev_seen = cur;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, step model on the edge, compare 1 ns later.
  task automatic cycle(input bit r, input bit raw);
    @(negedge clk);
    rst        = r;
    button_raw = raw;
    @(posedge clk);
    if (r) model_reset();
    else model_step(raw);
    #1;
    check("model_button", button, m_pulse);
    check("model_level", button_level, m_level);
    check("model_count", press_count, m_cnt);
  endtask

  typedef struct {
    bit         raw;
    bit         btn;
    bit         lvl;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[40];

  initial begin
    int pulses;
    int idx;
    int rel;

    // Clean press table: raw high at row 0 for 20 rows, then low.
    for (int k = 0; k < 40; k++) begin
      tbl[k].raw = (k < 20);
      tbl[k].btn = (k == D + 1);
      tbl[k].lvl = (k >= D + 1) && (k < 20 + D + 1);
      tbl[k].cnt = (k >= D + 1) ? 8'd1 : 8'd0;
    end

    rst        = 1'b1;
    button_raw = 1'b0;
    model_reset();

    // Reset held with raw high: outputs stay at reset values.
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1);
      check("rst_button", button, 1'b0);
      check("rst_level", button_level, 1'b0);
      check("rst_count", press_count, 8'd0);
    end
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 1'b0);
      check("post_rst_button", button, 1'b0);
      check("post_rst_level", button_level, 1'b0);
      check("post_rst_count", press_count, 8'd0);
    end

    // Clean press, table driven.
    for (int k = 0; k < 40; k++) begin
      cycle(1'b0, tbl[k].raw);
      check($sformatf("tbl_button[%0d]", k), button, tbl[k].btn);
      check($sformatf("tbl_level[%0d]", k), button_level, tbl[k].lvl);
      check($sformatf("tbl_count[%0d]", k), press_count, tbl[k].cnt);
    end

    // Press bounce: three-sample highs never reach the threshold.
    cycle(1'b1, 1'b0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      cycle(1'b0, (k % 4) != 3);
      if (button === 1'b1) pulses++;
    end
    check("bounce_pulses", pulses, 0);
    check("bounce_level", button_level, 1'b0);
    check("bounce_count", press_count, 8'd0);

    // Release bounce from HELD: two low samples then high again.
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1);
    check("relb_entry_level", button_level, 1'b1);
    check("relb_entry_count", press_count, 8'd1);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, k >= 2);
      check("relb_level", button_level, 1'b1);
      if (button === 1'b1) pulses++;
    end
`ifndef BUTTON_CONDITIONER_REPEAT_EN
    check("relb_pulses", pulses, 0);
    check("relb_count", press_count, 8'd1);
`endif
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0);
    check("relb_released", button_level, 1'b0);

    // Reset in the middle of ARM, raw kept high.
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    check("midarm_rst_button", button, 1'b0);
    check("midarm_rst_count", press_count, 8'd0);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b1);
      check($sformatf("midarm_button[%0d]", k), button, k == D + 1);
    end
    check("midarm_count", press_count, 8'd1);
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0);

    // 256 clean presses wrap the counter to zero.
    cycle(1'b1, 1'b0);
    pulses = 0;
    for (int p = 0; p < 256; p++) begin
      for (int k = 0; k < 16; k++) begin
        cycle(1'b0, k < 8);
        if (button === 1'b1) pulses++;
      end
    end
    check("wrap_pulses", pulses, 256);
    check("wrap_count", press_count, 8'd0);

`ifdef BUTTON_CONDITIONER_REPEAT_EN
    // Auto-repeat: pulses at HELD entry, +10, +15, +20, +25.
    cycle(1'b1, 1'b0);
    idx = -1;
    pulses = 0;
    for (int k = 0; k < D + 1 + 28; k++) begin
      cycle(1'b0, 1'b1);
      if (button === 1'b1) begin
        if (idx < 0) idx = k;
        rel = k - idx;
        check("rep_offset", rel, (pulses == 0) ? 0 : RD + (pulses - 1) * RP);
        pulses++;
      end
    end
    check("rep_pulses", pulses, 5);
    check("rep_count", press_count, 8'd5);
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0);
`endif

    // Randomised runs with occasional resets, checked against the model.
    for (int i = 0; i < 250; i++) begin
      int len;
      bit v;
      bit r;
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 8);
      v   = 1'($urandom_range(0, 1));
      r   = ($urandom_range(0, 39) == 0);
      for (int j = 0; j < len; j++) cycle(r && (j == 0), v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
